// File: rtl/usb_console_pkg.sv
// usb_console_pkg: shared encodings for the USB console command decoder.
//   state_e  - decoder FSM states
//   op_e     - latched command opcode
//   ASCII_*  - terminators and command letters (upper case)
//   to_upper / is_term - byte classification helpers
package usb_console_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARG     = 2'd1,
    ST_TERM    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_C    = 3'd1,
    OP_E    = 3'd2,
    OP_D    = 3'd3,
    OP_F    = 3'd4
  } op_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_F  = 8'h46;

  // Fold a-z onto A-Z so command letters match in either case.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/usb_hex_nibble.sv
// usb_hex_nibble: combinational ASCII hex digit decoder.
//   char_i [7:0] - ASCII byte
//   val_o  [3:0] - digit value (0 when not a hex digit)
//   vld_o        - byte is one of 0-9, A-F, a-f
module usb_hex_nibble (
  input  logic [7:0] char_i,
  output logic [3:0] val_o,
  output logic       vld_o
);

  always_comb begin
    val_o = 4'h0;
    vld_o = 1'b0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      val_o = char_i[3:0];
      vld_o = 1'b1;
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10..15.
      val_o = char_i[3:0] + 4'd9;
      vld_o = 1'b1;
    end
  end

endmodule

// File: rtl/usb_console_decoder.sv
// usb_console_decoder: line-oriented ASCII command decoder for a USB
// analyser console. Commands (case-insensitive, ended by CR or LF):
//   C      - request status redraw
//   E<hex> - set endpoint filter
//   D<0|1> - IN-direction filter enable
//   F<0|1> - freeze status capture
// Ports:
//   clk48, rst_n (sync, active low), rx_q/rx_dv (byte stream in),
//   ep_filter, dir_filter_en, freeze (persistent settings),
//   redraw, cmd_ok, cmd_err (one-cycle pulses), echo_q/echo_dv (echo).
// Optional feature: define USB_CONSOLE_ECHO_EN to echo every received
// byte one cycle later, with CR expanded to CR,LF. Without it the echo
// outputs are tied to 0.
module usb_console_decoder
  import usb_console_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 48000000
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] rx_q,
  input  logic       rx_dv,
  output logic [3:0] ep_filter,
  output logic       dir_filter_en,
  output logic       freeze,
  output logic       redraw,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] echo_q,
  output logic       echo_dv
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Firing while the counter holds TIMEOUT-2 puts cmd_err in the cycle
  // the count would reach TIMEOUT-1.
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT_CYCLES - 2);

  state_e        state_q;
  op_e           op_q;
  logic [3:0]    arg_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    ep_q;
  logic          dir_q, frz_q, redraw_q, ok_q, err_q;

  logic [7:0] up_c;
  logic       term_c, letter_arg_c, arg_ok_c, timeout_c;
  logic [3:0] nib_val;
  logic       nib_vld;
  op_e        op_d;

  usb_hex_nibble u_hex (
    .char_i (rx_q),
    .val_o  (nib_val),
    .vld_o  (nib_vld)
  );

  always_comb begin
    up_c         = to_upper(rx_q);
    term_c       = is_term(rx_q);
    letter_arg_c = (up_c == ASCII_E) || (up_c == ASCII_D) || (up_c == ASCII_F);
    op_d         = (up_c == ASCII_E) ? OP_E : (up_c == ASCII_D) ? OP_D : OP_F;
    // D/F take only '0'/'1': hex digits with value below 2.
    arg_ok_c     = nib_vld && ((op_q == OP_E) || (nib_val < 4'd2));
    timeout_c    = (state_q != ST_IDLE) && !rx_dv && (cnt_q == CNT_FIRE);
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      arg_q    <= 4'h0;
      cnt_q    <= '0;
      ep_q     <= 4'h0;
      dir_q    <= 1'b0;
      frz_q    <= 1'b0;
      redraw_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      redraw_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      if (state_q != ST_IDLE && cnt_q != {CW{1'b1}})
        cnt_q <= cnt_q + CW'(1);
      if (rx_dv) begin
        cnt_q <= '0;
        unique case (state_q)
          ST_IDLE: begin
            if (term_c) begin
              state_q <= ST_IDLE;
            end else if (up_c == ASCII_C) begin
              op_q    <= OP_C;
              state_q <= ST_TERM;
            end else if (letter_arg_c) begin
              op_q    <= op_d;
              state_q <= ST_ARG;
            end else begin
              state_q <= ST_DISCARD;
            end
          end
          ST_ARG: begin
            if (term_c) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (arg_ok_c) begin
              arg_q   <= nib_val;
              state_q <= ST_TERM;
            end else begin
              state_q <= ST_DISCARD;
            end
          end
          ST_TERM: begin
            if (term_c) begin
              ok_q    <= 1'b1;
              state_q <= ST_IDLE;
              unique case (op_q)
                OP_C:    redraw_q <= 1'b1;
                OP_E:    ep_q     <= arg_q;
                OP_D:    dir_q    <= arg_q[0];
                OP_F:    frz_q    <= arg_q[0];
                default: ;
              endcase
            end else begin
              state_q <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (term_c) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timeout_c) begin
        err_q   <= 1'b1;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign ep_filter     = ep_q;
  assign dir_filter_en = dir_q;
  assign freeze        = frz_q;
  assign redraw        = redraw_q;
  assign cmd_ok        = ok_q;
  assign cmd_err       = err_q;

`ifdef USB_CONSOLE_ECHO_EN
  logic [7:0] echo_q_q;
  logic       echo_dv_q, lf_pend_q;

  // Strobes are >=2 cycles apart, so the LF after a CR never collides
  // with the next byte's echo.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      echo_q_q  <= 8'h00;
      echo_dv_q <= 1'b0;
      lf_pend_q <= 1'b0;
    end else begin
      echo_dv_q <= 1'b0;
      lf_pend_q <= 1'b0;
      if (rx_dv) begin
        echo_q_q  <= rx_q;
        echo_dv_q <= 1'b1;
        lf_pend_q <= (rx_q == ASCII_CR);
      end else if (lf_pend_q) begin
        echo_q_q  <= ASCII_LF;
        echo_dv_q <= 1'b1;
      end
    end
  end

  assign echo_q  = echo_q_q;
  assign echo_dv = echo_dv_q;
`else
  assign echo_q  = 8'h00;
  assign echo_dv = 1'b0;
`endif

endmodule

// File: tb/tb_usb_console_decoder.sv
module tb_usb_console_decoder;
  localparam int TO = 16;

  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_q  = 8'h00;
  logic [3:0] ep_filter;
  logic       dir_filter_en, freeze, redraw, cmd_ok, cmd_err, echo_dv;
  logic [7:0] echo_q;

  always #5 clk48 = ~clk48;

  usb_console_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk48(clk48), .rst_n(rst_n), .rx_q(rx_q), .rx_dv(rx_dv),
    .ep_filter(ep_filter), .dir_filter_en(dir_filter_en), .freeze(freeze),
    .redraw(redraw), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
    .echo_q(echo_q), .echo_dv(echo_dv)
  );

  int checks = 0, errors = 0;
  int cyc = 0, ok_seen = 0, err_seen = 0, redraw_seen = 0, ok_cyc = 0, err_cyc = 0;

  // Reference model: a line buffer evaluated against the command grammar
  // when a terminator arrives, plus an idle-cycle count since the last byte.
  logic [7:0] line[$];
  int         idle = 0;
  logic [3:0] m_ep = 0;
  logic       m_dir = 0, m_frz = 0, m_redraw = 0, m_ok = 0, m_err = 0;
  logic [7:0] m_echo_q = 0;
  logic       m_echo_dv = 0, m_lfp = 0;

  function automatic logic [7:0] upc(input logic [7:0] b);
    return (b >= "a" && b <= "z") ? b - 8'd32 : b;
  endfunction

  function automatic int hexv(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic eval_line();
    logic [7:0] c0;
    int v;
    c0 = upc(line[0]);
    if (line.size() == 1 && c0 == "C") begin
      m_ok = 1; m_redraw = 1;
    end else if (line.size() == 2) begin
      v = hexv(line[1]);
      if (c0 == "E" && v >= 0) begin m_ok = 1; m_ep = 4'(v); end
      else if (c0 == "D" && (line[1] == "0" || line[1] == "1")) begin m_ok = 1; m_dir = line[1][0]; end
      else if (c0 == "F" && (line[1] == "0" || line[1] == "1")) begin m_ok = 1; m_frz = line[1][0]; end
      else m_err = 1;
    end else m_err = 1;
  endtask

  task automatic model(input logic r, input logic d, input logic [7:0] b);
    m_redraw = 0; m_ok = 0; m_err = 0;
    if (!r) begin
      line.delete(); idle = 0;
      m_ep = 0; m_dir = 0; m_frz = 0;
      m_echo_q = 0; m_echo_dv = 0; m_lfp = 0;
      return;
    end
`ifdef USB_CONSOLE_ECHO_EN
    m_echo_dv = 0;
    if (d) begin m_echo_q = b; m_echo_dv = 1; m_lfp = (b == 8'h0D); end
    else if (m_lfp) begin m_echo_q = 8'h0A; m_echo_dv = 1; m_lfp = 0; end
`endif
    if (d) begin
      idle = 0;
      if (b == 8'h0D || b == 8'h0A) begin
        if (line.size() > 0) eval_line();
        line.delete();
      end else line.push_back(b);
    end else if (line.size() > 0) begin
      idle++;
      if (idle == TO - 1) begin m_err = 1; line.delete(); idle = 0; end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare every output after the edge.
  task automatic step(input logic r, input logic d, input logic [7:0] b);
    cyc++;
    rst_n = r; rx_dv = d;
    rx_q  = d ? b : 8'($urandom);
    model(r, d, b);
    @(posedge clk48); #1;
    chk("ep_filter", 8'(ep_filter), 8'(m_ep));
    chk("dir_filter_en", 8'(dir_filter_en), 8'(m_dir));
    chk("freeze", 8'(freeze), 8'(m_frz));
    chk("redraw", 8'(redraw), 8'(m_redraw));
    chk("cmd_ok", 8'(cmd_ok), 8'(m_ok));
    chk("cmd_err", 8'(cmd_err), 8'(m_err));
    chk("echo_dv", 8'(echo_dv), 8'(m_echo_dv));
    if (m_echo_dv) chk("echo_q", echo_q, m_echo_q);
    if (!r) chk("echo_q_rst", echo_q, 8'h00);
    chk("ok_err_excl", 8'(cmd_ok & cmd_err), 8'h00);
    chk("redraw_wo_ok", 8'(redraw & ~cmd_ok), 8'h00);
    if (cmd_ok === 1'b1) begin ok_seen++; ok_cyc = cyc + 1; end
    if (cmd_err === 1'b1) begin err_seen++; err_cyc = cyc + 1; end
    if (redraw === 1'b1) redraw_seen++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1, 1, b);
    repeat (gap) step(1, 0, 8'h00);
  endtask

  initial begin
    int o, e, rd, s, g;
    logic [7:0] alpha[34];
    string al;
    al = "CcEeDdFf0123456789abcdefABCDEFXz";
    for (int i = 0; i < 32; i++) alpha[i] = al[i];
    alpha[32] = 8'h0D; alpha[33] = 8'h0A;

    repeat (3) step(0, 0, 8'h00);
    chk("rst_ep", 8'(ep_filter), 8'h00);
    chk("rst_pulses", {5'd0, cmd_ok, cmd_err, redraw}, 8'h00);

    // "E","b",CR one byte per 4 cycles
    o = ok_seen;
    send("E", 3); send("b", 3);
    step(1, 1, 8'h0D); s = cyc;
    repeat (3) step(1, 0, 8'h00);
    chk("e_b_ep", 8'(ep_filter), 8'h0B);
    chk("e_b_okcnt", 8'(ok_seen - o), 8'd1);
    chk("e_b_oklat", 8'(ok_cyc - s), 8'd1);

    // freeze on via LF, off via CR
    o = ok_seen; e = err_seen;
    send("f", 3); send("1", 3); send(8'h0A, 3);
    chk("frz_on", 8'(freeze), 8'h01);
    send("F", 3); send("0", 3); send(8'h0D, 3);
    chk("frz_off", 8'(freeze), 8'h00);
    chk("frz_okcnt", 8'(ok_seen - o), 8'd2);
    chk("frz_errcnt", 8'(err_seen - e), 8'd0);

    // bad argument, bad letter, lone terminator
    e = err_seen; o = ok_seen;
    send("D", 3); send("7", 3); send(8'h0D, 3);
    chk("d7_err", 8'(err_seen - e), 8'd1);
    chk("d7_dir", 8'(dir_filter_en), 8'h00);
    send("X", 3); send(8'h0D, 3);
    chk("x_err", 8'(err_seen - e), 8'd2);
    send(8'h0D, 3);
    chk("lone_cr", 8'(err_seen - e + ok_seen - o), 8'd2);

    // timeout after a lone "E", then C redraw
    e = err_seen;
    step(1, 1, "E"); s = cyc;
    repeat (17) step(1, 0, 8'h00);
    chk("to_err", 8'(err_seen - e), 8'd1);
    chk("to_lat", 8'(err_cyc - s), 8'd16);
    o = ok_seen; rd = redraw_seen;
    send("C", 3); send(8'h0D, 3);
    chk("c_ok", 8'(ok_seen - o), 8'd1);
    chk("c_redraw", 8'(redraw_seen - rd), 8'd1);

    // reset mid-command discards the line silently
    o = ok_seen; e = err_seen;
    send("E", 3); send("5", 3);
    step(0, 0, 8'h00);
    send(8'h0D, 4);
    chk("rst_mid_ep", 8'(ep_filter), 8'h00);
    chk("rst_mid_pulses", 8'(ok_seen - o + err_seen - e), 8'd0);

    // randomized traffic, including timeout-boundary gaps and resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) step(0, 0, 8'h00);
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(1, 4);
      send(alpha[$urandom_range(0, 33)], g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_console_decoder.md
USB_CONSOLE_DECODER -- requirements
Module: usb_console_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 48000000, is the inter-byte idle limit in clk48 cycles before a partial command is abandoned.
REQ-002 clk48  input  1  single 48 MHz clock; all logic on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 rx_q  input  8  ASCII byte from the host console stream.
REQ-005 rx_dv  input  1  one-cycle strobe; rx_q is valid on that cycle; strobes are at least 2 cycles apart.
REQ-006 ep_filter  output  4  selected endpoint filter value.
REQ-007 dir_filter_en  output  1  IN-direction filter enable.
REQ-008 freeze  output  1  status-capture freeze.
REQ-009 redraw  output  1  one-cycle pulse requesting a full status-screen redraw.
REQ-010 cmd_ok  output  1  one-cycle pulse when a command executes.
REQ-011 cmd_err  output  1  one-cycle pulse when a line is rejected or times out.
REQ-012 echo_q  output  8  echoed byte.
REQ-013 echo_dv  output  1  one-cycle echo strobe.

Function
REQ-014 The FSM SHALL have states IDLE, ARG, TERM and DISCARD, and SHALL advance only on cycles with rx_dv high, except on timeout.
REQ-015 Terminators are CR (0x0D) and LF (0x0A); command letters C, E, D and F SHALL be accepted in upper or lower case.
REQ-016 IDLE: C goes to TERM; E, D or F latches the opcode and goes to ARG; a terminator stays in IDLE with no pulse; any other byte goes to DISCARD.
REQ-017 ARG: a valid argument latches the 4-bit value and goes to TERM, where valid is a hex digit 0-9/A-F/a-f for E and 0 or 1 for D and F.
REQ-018 ARG: a terminator pulses cmd_err and returns to IDLE; any other byte goes to DISCARD.
REQ-019 TERM: a terminator executes the command and returns to IDLE; any other byte goes to DISCARD.
REQ-020 Execution: C pulses redraw; E loads ep_filter; D loads dir_filter_en; F loads freeze; every execution pulses cmd_ok.
REQ-021 Executed outputs SHALL change on the same clock edge that samples the terminator, so they are visible one cycle after the rx_dv cycle.
REQ-022 DISCARD: a terminator pulses cmd_err and returns to IDLE; all other bytes are ignored.
REQ-023 The idle counter SHALL clear on every rx_dv and on entry to IDLE, and SHALL count only outside IDLE.
REQ-024 When the idle counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse cmd_err and return to IDLE; if rx_dv occurs in that same cycle, the byte is processed and no timeout occurs.
REQ-025 cmd_ok and cmd_err SHALL never assert in the same cycle, and redraw SHALL assert only together with cmd_ok.
REQ-026 The idle counter SHALL be sized by $clog2(TIMEOUT_CYCLES) and SHALL saturate rather than wrap.

Reset
REQ-027 While rst_n is low at a clock edge, the block SHALL enter IDLE, clear the latched opcode, argument and idle counter, and drive ep_filter=0, dir_filter_en=0, freeze=0, redraw=0, cmd_ok=0, cmd_err=0, echo_q=0 and echo_dv=0.
REQ-028 A reset mid-command SHALL discard the partial line with no cmd_err pulse.

Configuration
REQ-029 With USB_CONSOLE_ECHO_EN defined, every accepted byte SHALL appear on echo_q with echo_dv one cycle after its rx_dv.
REQ-030 With USB_CONSOLE_ECHO_EN defined, an echoed CR SHALL be followed on the next cycle by echo_q=LF with echo_dv high.
REQ-031 Without USB_CONSOLE_ECHO_EN, echo_q and echo_dv SHALL be held at 0, the ports SHALL remain present, and the command function SHALL be unchanged.

Structure
REQ-032 Package usb_console_pkg SHALL hold the state encoding, opcode encoding and ASCII constants (CR, LF, command letters).
REQ-033 Sub-module usb_hex_nibble SHALL be combinational and map an ASCII byte to a 4-bit value plus a valid flag; it is instantiated once.

Verification
REQ-034 Bytes "E","b",CR, one per 4 cycles -> ep_filter=0xB and cmd_ok pulses once, one cycle after the CR strobe.
REQ-035 Bytes "f","1",LF then "F","0",CR -> freeze goes 1 then 0, with two cmd_ok pulses and no cmd_err.
REQ-036 Bytes "D","7",CR -> one cmd_err, dir_filter_en unchanged; then bytes "X",CR -> one cmd_err; a lone CR -> no pulse.
REQ-037 TIMEOUT_CYCLES=16: byte "E" then 16 idle cycles -> cmd_err 16 cycles after the "E" strobe; then "C",CR -> redraw and cmd_ok pulse together.
REQ-038 Bytes "E","5" then rst_n low for 1 cycle, then CR -> ep_filter stays 0, no pulses; with USB_CONSOLE_ECHO_EN, the CR echoes as 0x0D followed by 0x0A on consecutive cycles.
